// File: rtl/riscv_apb_mem.sv
// APB completer memory with word-addressed storage and programmable wait states.
// Defining RISCV_APB_MEM_SLVERR_EN adds pslverr_o and rejects out-of-range addresses.
module riscv_apb_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o
`ifdef RISCV_APB_MEM_SLVERR_EN
    ,
    output logic        pslverr_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_ACCESS = 1'b1;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic [31:0]   prdata_q, prdata_d;
    logic          err_q, err_d;

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          addrErr;
    logic          setup;
    logic          complete;
    logic          memWe;
    logic          unused_addr_bits;

    assign offset = paddr_i - BASE_ADDR;
    assign idx    = offset[AW+1:2];
    assign unused_addr_bits = ^{offset[1:0], offset[31:AW+2]};

`ifdef RISCV_APB_MEM_SLVERR_EN
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    assign addrErr   = (paddr_i < BASE_ADDR) || ({1'b0, offset} >= LIMIT);
    assign pslverr_o = pready_o & err_q;
`else
    assign addrErr = 1'b0;
`endif

    // pready is decoded from registered state only, never from the bus inputs.
    assign pready_o = (state_q == STATE_ACCESS) && (cnt_q == 4'd0);
    assign prdata_o = prdata_q;
    assign setup    = psel_i & ~penable_i;
    assign complete = (state_q == STATE_ACCESS) & psel_i & penable_i & pready_o;
    assign memWe    = complete & pwrite_q & ~err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        prdata_d = prdata_q;
        err_d    = err_q;
        case (state_q)
            STATE_IDLE: begin
                if (setup) begin
                    idx_d    = idx;
                    pwrite_d = pwrite_i;
                    pwdata_d = pwdata_i;
                    cnt_d    = 4'(WAIT_CYCLES);
                    err_d    = addrErr;
                    if (!pwrite_i) begin
                        prdata_d = addrErr ? 32'h0 : mem[idx];
                    end
                    state_d  = STATE_ACCESS;
                end
            end
            default: begin
                // Completion returns to IDLE so a following setup is taken there with no gap.
                if (!psel_i) begin
                    state_d = STATE_IDLE;
                end else if (penable_i) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = STATE_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STATE_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= 32'h0;
            prdata_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            prdata_q <= prdata_d;
            err_q    <= err_d;
        end
    end

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[idx_q] <= pwdata_q;
        end
    end

endmodule

// File: tb/tb_riscv_apb_mem.sv
// Self-checking bench for riscv_apb_mem: three instances with different depth, wait and base settings
// exercised by directed scenarios and a randomized mix against a word-array reference model.
module tb_riscv_apb_mem;

   logic clk = 1'b0;
   logic reset;
   logic [2:0] psel;
   logic penable;
   logic pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [2:0] prdy;
   logic [2:0][31:0] prd;
   logic [2:0] slv;

   int compared = 0;
   int mismatched = 0;
   logic [31:0] model [3][16];

   always #5 clk = ~clk;

   riscv_apb_mem #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .reset(reset), .psel_i(psel[0]), .penable_i(penable), .paddr_i(paddr),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(prdy[0]), .prdata_o(prd[0])
`ifdef RISCV_APB_MEM_SLVERR_EN
      , .pslverr_o(slv[0])
`endif
   );

   riscv_apb_mem #(.DEPTH_WORDS(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h1000)) dut1 (
      .clk(clk), .reset(reset), .psel_i(psel[1]), .penable_i(penable), .paddr_i(paddr),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(prdy[1]), .prdata_o(prd[1])
`ifdef RISCV_APB_MEM_SLVERR_EN
      , .pslverr_o(slv[1])
`endif
   );

   riscv_apb_mem #(.DEPTH_WORDS(4), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut2 (
      .clk(clk), .reset(reset), .psel_i(psel[2]), .penable_i(penable), .paddr_i(paddr),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(prdy[2]), .prdata_o(prd[2])
`ifdef RISCV_APB_MEM_SLVERR_EN
      , .pslverr_o(slv[2])
`endif
   );

`ifndef RISCV_APB_MEM_SLVERR_EN
   assign slv = 3'b000;
`endif

   // Per-instance configuration, mirroring the parameter overrides above.
   function automatic int depthOf(input int d);
      return (d == 2) ? 4 : 16;
   endfunction

   function automatic int waitOf(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
   endfunction

   function automatic logic [31:0] baseOf(input int d);
      return (d == 1) ? 32'h1000 : 32'h0;
   endfunction

   // Word index seen by the memory: byte offset from base, in words, modulo depth.
   function automatic int idxOf(input int d, input logic [31:0] addr);
      logic [31:0] off;
      off = addr - baseOf(d);
      return int'((off >> 2) % 32'(depthOf(d)));
   endfunction

   function automatic bit errOf(input int d, input logic [31:0] addr);
`ifdef RISCV_APB_MEM_SLVERR_EN
      logic [31:0] off;
      off = addr - baseOf(d);
      return (addr < baseOf(d)) || ({1'b0, off} >= 33'(4 * depthOf(d)));
`else
      return (d < 0) && (addr == 32'h0);
`endif
   endfunction

   function automatic logic [31:0] expRead(input int d, input logic [31:0] addr);
      return errOf(d, addr) ? 32'h0 : model[d][idxOf(d, addr)];
   endfunction

   // Drives one setup + access sequence and returns what the completer showed in its completion cycle.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int acc, output logic err);
      @(negedge clk);
      psel = 3'b000;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite = wr;
      paddr = addr;
      pwdata = wdata;
      @(negedge clk);
      penable = 1'b1;
      acc = 1;
      while (prdy[d] !== 1'b1 && acc < 40) begin
         @(negedge clk);
         acc++;
      end
      rdata = prd[d];
      err = slv[d];
      if (prdy[d] === 1'b1 && wr && !errOf(d, addr)) model[d][idxOf(d, addr)] = wdata;
   endtask

   task automatic idle();
      @(negedge clk);
      psel = 3'b000;
      penable = 1'b0;
   endtask

   task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output int acc, output logic err);
      xfer(d, wr, addr, wdata, rdata, acc, err);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      psel = 3'b000;
      penable = 1'b0;
      pwrite = 1'b0;
      paddr = 32'h0;
      pwdata = 32'h0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         compared++;
         if (prdy[d] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_pready dut%0d: got %b want 0", d, prdy[d]);
         end
         compared++;
         if (prd[d] !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_prdata dut%0d: got %h want 0", d, prd[d]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_init();
      logic [31:0] r;
      int acc;
      logic e;
      for (int d = 0; d < 3; d++) begin
         for (int w = 0; w < depthOf(d); w++) begin
            applyStimulus(d, 1'b1, baseOf(d) + 32'(4 * w), $urandom, r, acc, e);
            compared++;
            if (acc !== waitOf(d) + 1) begin
               mismatched++;
               $display("[TB] FAIL init_latency dut%0d w%0d: got %0d want %0d", d, w, acc, waitOf(d) + 1);
            end
         end
         idle();
      end
   endtask

   task automatic test_wait0();
      logic [31:0] r;
      int acc;
      logic e;
      applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, r, acc, e);
      compared++;
      if (acc !== 1) begin
         mismatched++;
         $display("[TB] FAIL wait0_write_latency: got %0d want 1", acc);
      end
      idle();
      applyStimulus(0, 1'b0, 32'h10, 32'h0, r, acc, e);
      compared++;
      if (acc !== 1) begin
         mismatched++;
         $display("[TB] FAIL wait0_read_latency: got %0d want 1", acc);
      end
      compared++;
      if (r !== 32'hDEADBEEF) begin
         mismatched++;
         $display("[TB] FAIL wait0_read_data: got %h want deadbeef", r);
      end
      idle();
   endtask

   task automatic test_wait2();
      logic [31:0] r;
      logic [31:0] want;
      int acc;
      logic e;
      want = expRead(1, 32'h100C);
      applyStimulus(1, 1'b0, 32'h100C, 32'h0, r, acc, e);
      compared++;
      if (acc + 1 !== 4) begin
         mismatched++;
         $display("[TB] FAIL wait2_total_cycles: got %0d want 4", acc + 1);
      end
      compared++;
      if (r !== want) begin
         mismatched++;
         $display("[TB] FAIL wait2_read_data: got %h want %h", r, want);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      int acc;
      logic e;
      for (int d = 0; d < 2; d++) begin
         applyStimulus(d, 1'b1, baseOf(d) + 32'h4, 32'h1, r, acc, e);
         applyStimulus(d, 1'b0, baseOf(d) + 32'h4, 32'h0, r, acc, e);
         compared++;
         if (r !== 32'h1 || acc !== waitOf(d) + 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_raw dut%0d: got data %h lat %0d want 1 lat %0d", d, r, acc, waitOf(d) + 1);
         end
      end
      idle();
   endtask

   task automatic test_abort();
      logic [31:0] r;
      logic [31:0] old;
      int acc;
      logic e;
      old = model[1][idxOf(1, 32'h1008)];
      @(negedge clk);
      psel = 3'b010;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 32'h1008;
      pwdata = ~old;
      @(negedge clk);
      psel = 3'b000;
      compared++;
      if (prdy[1] !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_pready: got %b want 0", prdy[1]);
      end
      applyStimulus(1, 1'b0, 32'h1008, 32'h0, r, acc, e);
      compared++;
      if (r !== old || acc !== 3) begin
         mismatched++;
         $display("[TB] FAIL abort_read: got %h lat %0d want %h lat 3", r, acc, old);
      end
      idle();
   endtask

   task automatic test_protocol();
      @(negedge clk);
      psel = 3'b001;
      penable = 1'b1;
      pwrite = 1'b1;
      paddr = 32'h18;
      pwdata = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compared++;
         if (prdy[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL protocol_pready cycle%0d: got %b want 0", i, prdy[0]);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic [31:0] old;
      int acc;
      logic e;
      old = model[0][idxOf(0, 32'h14)];
      @(negedge clk);
      psel = 3'b001;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 32'h14;
      pwdata = ~old;
      @(negedge clk);
      penable = 1'b1;
      compared++;
      if (prdy[0] !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL midreset_pre_pready: got %b want 1", prdy[0]);
      end
      #2 reset = 1'b1;
      #1;
      compared++;
      if (prdy[0] !== 1'b0 || prd[0] !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL midreset_async: got pready %b prdata %h want 0 0", prdy[0], prd[0]);
      end
      reset = 1'b0;
      psel = 3'b000;
      penable = 1'b0;
      applyStimulus(0, 1'b0, 32'h14, 32'h0, r, acc, e);
      compared++;
      if (r !== old || acc !== 1) begin
         mismatched++;
         $display("[TB] FAIL midreset_readback: got %h lat %0d want %h lat 1", r, acc, old);
      end
      idle();
   endtask

   task automatic test_depth4();
      logic [31:0] r;
      logic [31:0] old;
      int acc;
      logic e;
      old = model[2][0];
      applyStimulus(2, 1'b1, 32'h10, 32'hCAFEF00D, r, acc, e);
`ifdef RISCV_APB_MEM_SLVERR_EN
      compared++;
      if (e !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL depth4_slverr: got %b want 1", e);
      end
`endif
      idle();
      applyStimulus(2, 1'b0, 32'h0, 32'h0, r, acc, e);
      compared++;
`ifdef RISCV_APB_MEM_SLVERR_EN
      if (r !== old) begin
         mismatched++;
         $display("[TB] FAIL depth4_word0: got %h want %h", r, old);
      end
`else
      if (r !== 32'hCAFEF00D) begin
         mismatched++;
         $display("[TB] FAIL depth4_alias: got %h want cafef00d", r);
      end
`endif
      idle();
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [31:0] addr;
      logic [31:0] want;
      logic [31:0] wdata;
      int acc;
      logic e;
      int d;
      bit wr;
      bit wantErr;
      for (int i = 0; i < 80; i++) begin
         d = int'($urandom_range(0, 2));
         wr = 1'($urandom_range(0, 1));
         addr = baseOf(d) + 32'($urandom_range(0, 127));
         wdata = $urandom;
         want = expRead(d, addr);
         wantErr = errOf(d, addr);
         applyStimulus(d, wr, addr, wdata, r, acc, e);
         compared++;
         if (acc !== waitOf(d) + 1) begin
            mismatched++;
            $display("[TB] FAIL rand_latency #%0d dut%0d: got %0d want %0d", i, d, acc, waitOf(d) + 1);
         end
         if (!wr) begin
            compared++;
            if (r !== want) begin
               mismatched++;
               $display("[TB] FAIL rand_read #%0d dut%0d addr %h: got %h want %h", i, d, addr, r, want);
            end
         end
`ifdef RISCV_APB_MEM_SLVERR_EN
         compared++;
         if (e !== wantErr) begin
            mismatched++;
            $display("[TB] FAIL rand_slverr #%0d dut%0d addr %h: got %b want %b", i, d, addr, e, wantErr);
         end
`endif
         if ($urandom_range(0, 1) == 0) idle();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_init();
      test_wait0();
      test_wait2();
      test_back_to_back();
      test_abort();
      test_protocol();
      test_reset_mid();
      test_depth4();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
